// File: rtl/dec_i2c_pkg.sv
// Shared types and constants for the dec_i2c passive I2C address decoder.
package dec_i2c_pkg;

  localparam int ADDR_W = 7;
  localparam logic [ADDR_W-1:0] GENERAL_CALL_ADDR = 7'h00;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR      = 2'd1,
    ACK       = 2'd2,
    WAIT_STOP = 2'd3
  } state_e;

  // Address comparison; gc_en additionally accepts the general-call address.
  function automatic logic addr_match(input logic [ADDR_W-1:0] rx_addr,
                                      input logic [ADDR_W-1:0] local_addr,
                                      input logic              gc_en);
    return (rx_addr == local_addr) || (gc_en && (rx_addr == GENERAL_CALL_ADDR));
  endfunction

endpackage

// File: rtl/dec_i2c_line_sync.sv
// Multi-flop synchronizer for one bus line plus a previous-value flop for edge detection.
module i2c_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchronizer chain and edge-detect history; preset high to match an idle bus.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{1'b1}};
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], line_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/dec_i2c.sv
// Passive I2C monitor: decodes START/STOP, the address byte and R/W bit.
// Optional build macro I2C_GENERAL_CALL_EN also accepts address 7'h00 as a match.
module dec_i2c #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sda,
  input  logic              scl,
  input  logic [ADDR_W-1:0] endereco_local,
  input  logic              pronto,
  output logic              operacao,
  output logic              escrita,
  output logic              stop,
  output logic [ADDR_W-1:0] endereco_recebido
);

  import dec_i2c_pkg::*;

`ifdef I2C_GENERAL_CALL_EN
  localparam logic GC_EN = 1'b1;
`else
  localparam logic GC_EN = 1'b0;
`endif

  logic sda_lvl_s, sda_rise_s, sda_fall_s;
  logic scl_lvl_s, scl_rise_s, scl_fall_s;
  logic start_s, stop_ev_s, bit_s;
  logic [7:0] byte_s;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              operacao_q, operacao_d;
  logic              escrita_q, escrita_d;
  logic              stop_q, stop_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sync_sda (
    .clk    (clk),
    .rst_ni (reset),
    .line_i (sda),
    .level_o(sda_lvl_s),
    .rise_o (sda_rise_s),
    .fall_o (sda_fall_s)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sync_scl (
    .clk    (clk),
    .rst_ni (reset),
    .line_i (scl),
    .level_o(scl_lvl_s),
    .rise_o (scl_rise_s),
    .fall_o (scl_fall_s)
  );

  // START/STOP use the current (post-change) scl level; a bit is not counted if sda moved too.
  assign start_s   = sda_fall_s & scl_lvl_s;
  assign stop_ev_s = sda_rise_s & scl_lvl_s;
  assign bit_s     = scl_rise_s & ~sda_rise_s & ~sda_fall_s;
  assign byte_s    = {shift_q[6:0], sda_lvl_s};

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      operacao_q <= 1'b0;
      escrita_q  <= 1'b0;
      stop_q     <= 1'b0;
      addr_q     <= {ADDR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      operacao_q <= operacao_d;
      escrita_q  <= escrita_d;
      stop_q     <= stop_d;
      addr_q     <= addr_d;
    end
  end

  // Next-state decode; STOP outranks START, both outrank bit shifting.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    operacao_d = operacao_q;
    escrita_d  = escrita_q;
    stop_d     = 1'b0;
    addr_d     = addr_q;
    if (stop_ev_s) begin
      state_d    = IDLE;
      cnt_d      = 4'd0;
      operacao_d = 1'b0;
      escrita_d  = 1'b0;
      stop_d     = 1'b1;
    end else if (start_s) begin
      state_d    = ADDR;
      cnt_d      = 4'd0;
      shift_d    = 8'h00;
      operacao_d = 1'b0;
      escrita_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        ADDR: begin
          if (bit_s) begin
            shift_d = byte_s;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              addr_d     = byte_s[7:1];
              escrita_d  = ~byte_s[0];
              operacao_d = addr_match(byte_s[7:1], endereco_local, GC_EN) && pronto;
              state_d    = ACK;
            end else begin
              state_d = ADDR;
            end
          end else begin
            state_d = ADDR;
          end
        end
        ACK: begin
          if (bit_s) begin
            state_d = WAIT_STOP;
          end else begin
            state_d = ACK;
          end
        end
        WAIT_STOP: begin
          state_d = WAIT_STOP;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign operacao          = operacao_q;
  assign escrita           = escrita_q;
  assign stop              = stop_q;
  assign endereco_recebido = addr_q;

endmodule

// File: tb/tb_dec_i2c.sv
// Directed bench for dec_i2c: 50 MHz clk, 100 ns SCL bit period (60 ns low / 40 ns high).
module tb_dec_i2c;

  logic       clk = 1'b0;
  logic       reset;
  logic       sda;
  logic       scl;
  logic [6:0] endereco_local;
  logic       pronto;
  logic       operacao;
  logic       escrita;
  logic       stop;
  logic [6:0] endereco_recebido;

  int checks = 0;
  int fails  = 0;
  int stop_hi = 0;
  int stop_base;

  dec_i2c #(.SYNC_STAGES(2), .ADDR_W(7)) dut (
    .clk              (clk),
    .reset            (reset),
    .sda              (sda),
    .scl              (scl),
    .endereco_local   (endereco_local),
    .pronto           (pronto),
    .operacao         (operacao),
    .escrita          (escrita),
    .stop             (stop),
    .endereco_recebido(endereco_recebido)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (stop === 1'b1) stop_hi++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    scl = 1'b0; tick(1);
    sda = b;    tick(2);
    scl = 1'b1; tick(2);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic i2c_start();
    scl = 1'b0; tick(1);
    sda = 1'b1; tick(2);
    scl = 1'b1; tick(2);
    sda = 1'b0; tick(2);
  endtask

  task automatic i2c_stop();
    scl = 1'b0; tick(1);
    sda = 1'b0; tick(2);
    scl = 1'b1; tick(2);
    sda = 1'b1; tick(4);
  endtask

  task automatic test_reset();
    reset = 1'b0; sda = 1'b1; scl = 1'b0; endereco_local = 7'h64; pronto = 1'b0;
    tick(3);
    chk("reset_operacao", {7'd0, operacao}, 8'h00);
    chk("reset_escrita",  {7'd0, escrita},  8'h00);
    chk("reset_stop",     {7'd0, stop},     8'h00);
    chk("reset_addr",     {1'b0, endereco_recebido}, 8'h00);
    reset = 1'b1;
    stop_base = stop_hi;
    for (int i = 0; i < 2; i++) begin
      scl = 1'b1; tick(3);
      scl = 1'b0; tick(3);
    end
    chk("idle_operacao", {7'd0, operacao}, 8'h00);
    chk("idle_escrita",  {7'd0, escrita},  8'h00);
    chk("idle_addr",     {1'b0, endereco_recebido}, 8'h00);
    chk("idle_no_stop",  8'(stop_hi - stop_base), 8'h00);
  endtask

  task automatic test_write_not_ready();
    endereco_local = 7'h64; pronto = 1'b0;
    i2c_start();
    send_byte(8'hC8);
    tick(3);
    chk("wnr_addr",     {1'b0, endereco_recebido}, 8'h64);
    chk("wnr_escrita",  {7'd0, escrita},  8'h01);
    chk("wnr_operacao", {7'd0, operacao}, 8'h00);
    send_bit(1'b0);
    stop_base = stop_hi;
    i2c_stop();
    chk("wnr_stop_width", 8'(stop_hi - stop_base), 8'h01);
    chk("wnr_escrita_after_stop", {7'd0, escrita}, 8'h00);
    chk("wnr_addr_hold", {1'b0, endereco_recebido}, 8'h64);
  endtask

  task automatic test_addressed_write();
    endereco_local = 7'h64; pronto = 1'b1;
    i2c_start();
    send_byte(8'hC8);
    tick(3);
    chk("aw_operacao", {7'd0, operacao}, 8'h01);
    chk("aw_escrita",  {7'd0, escrita},  8'h01);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("aw_operacao_hold", {7'd0, operacao}, 8'h01);
    stop_base = stop_hi;
    i2c_stop();
    chk("aw_stop_width", 8'(stop_hi - stop_base), 8'h01);
    chk("aw_operacao_after_stop", {7'd0, operacao}, 8'h00);
  endtask

  task automatic test_mismatch_read();
    endereco_local = 7'h64; pronto = 1'b1;
    i2c_start();
    send_byte(8'hA5);
    tick(3);
    chk("mr_addr",     {1'b0, endereco_recebido}, 8'h52);
    chk("mr_escrita",  {7'd0, escrita},  8'h00);
    chk("mr_operacao", {7'd0, operacao}, 8'h00);
    send_bit(1'b1);
    i2c_stop();
  endtask

  task automatic test_repeated_start();
    endereco_local = 7'h64; pronto = 1'b1;
    i2c_start();
    send_byte(8'hC8);
    tick(3);
    chk("rs_first_operacao", {7'd0, operacao}, 8'h01);
    send_bit(1'b0);
    i2c_start();
    tick(1);
    chk("rs_start_operacao", {7'd0, operacao}, 8'h00);
    chk("rs_start_escrita",  {7'd0, escrita},  8'h00);
    chk("rs_start_addr_hold", {1'b0, endereco_recebido}, 8'h64);
    send_byte(8'hC9);
    tick(3);
    chk("rs_operacao", {7'd0, operacao}, 8'h01);
    chk("rs_escrita",  {7'd0, escrita},  8'h00);
    send_bit(1'b0);
    i2c_stop();
  endtask

  task automatic test_reset_mid_address();
    endereco_local = 7'h64; pronto = 1'b1;
    i2c_start();
    send_byte(8'hFF);
    tick(3);
    send_bit(1'b0);
    i2c_start();
    for (int i = 7; i >= 4; i--) send_bit(1'b1);
    reset = 1'b0;
    tick(1);
    chk("rm_addr",     {1'b0, endereco_recebido}, 8'h00);
    chk("rm_operacao", {7'd0, operacao}, 8'h00);
    chk("rm_escrita",  {7'd0, escrita},  8'h00);
    sda = 1'b1; scl = 1'b1; tick(4);
    reset = 1'b1; tick(4);
    i2c_start();
    send_byte(8'hC8);
    tick(3);
    chk("rm_next_addr",     {1'b0, endereco_recebido}, 8'h64);
    chk("rm_next_operacao", {7'd0, operacao}, 8'h01);
    chk("rm_next_escrita",  {7'd0, escrita},  8'h01);
    send_bit(1'b0);
    i2c_stop();
  endtask

  task automatic test_general_call();
    endereco_local = 7'h64; pronto = 1'b1;
    i2c_start();
    send_byte(8'h00);
    tick(3);
    chk("gc_addr",    {1'b0, endereco_recebido}, 8'h00);
    chk("gc_escrita", {7'd0, escrita}, 8'h01);
`ifdef I2C_GENERAL_CALL_EN
    chk("gc_operacao", {7'd0, operacao}, 8'h01);
`else
    chk("gc_operacao", {7'd0, operacao}, 8'h00);
`endif
    send_bit(1'b0);
    i2c_stop();
  endtask

  initial begin
    tick(1);
    test_reset();
    test_write_not_ready();
    test_addressed_write();
    test_mismatch_read();
    test_repeated_start();
    test_reset_mid_address();
    test_general_call();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
